// File: rtl/uart_pkg.sv
// Shared definitions for the UART word transmitter: FSM state codes, line levels
// and the baud-counter sizing helper.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE   = 3'd0;
  localparam uart_state_t S_START  = 3'd1;
  localparam uart_state_t S_DATA   = 3'd2;
  localparam uart_state_t S_PARITY = 3'd3;
  localparam uart_state_t S_STOP   = 3'd4;
  localparam uart_state_t S_HOLD   = 3'd5;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned baud_cnt_w(input int unsigned clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clr_i restarts the period so every FSM state begins on a full bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 108
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CNT_W = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: one handshaked word goes out as WORD_BYTES frames,
// with cts_stop honoured only between frames. Define UART_TX_PARITY_EN for even parity.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 108,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned MSB_BYTE_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic                    cts_stop,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned W = 8 * WORD_BYTES;
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
`endif

  uart_state_t    state_q, state_d;
  logic [W-1:0]   word_q, word_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic           busy_q, busy_d;
  logic           tx_q, tx_d;
  logic           en_q;
  logic           bit_end;
  logic           accept;
  logic [1:0]     lane_sel;
  logic [7:0]     lane;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .bit_end_o(bit_end)
  );

  // en_q keeps word_ready low while reset is asserted and until the first edge after it.
  assign word_ready = en_q && (state_q == S_IDLE) && !cts_stop;
  assign accept     = word_valid && word_ready;
  assign frame_done = (state_q == S_STOP) && bit_end && (bit_idx_q == LAST_STOP);
  assign busy       = busy_q;
  assign tx         = tx_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d     = word_in;
          busy_d     = 1'b1;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q != LAST_STOP) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else if (byte_idx_q == LAST_BYTE) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = '0;
            state_d    = cts_stop ? S_HOLD : S_START;
          end
        end
      end
      S_HOLD: begin
        if (!cts_stop) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered, so its next value is derived from the next-state terms.
  always_comb begin
    lane_sel = (MSB_BYTE_FIRST != 0) ? (LAST_BYTE - byte_idx_d) : byte_idx_d;
    lane     = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (lane_sel == 2'(i)) lane = word_d[8*i +: 8];
    end
  end

  always_comb begin
    case (state_d)
      S_START:  tx_d = START_BIT;
      S_DATA:   tx_d = lane[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^(lane & DATA_MASK);
`endif
      S_STOP:   tx_d = STOP_BIT;
      default:  tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      tx_q       <= LINE_IDLE;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      en_q       <= 1'b1;
    end
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Parametrised UART transmitter that accepts one multi-byte sample word (e.g. 32-bit CIC output) over a valid/ready handshake and serialises it as WORD_BYTES consecutive UART frames, LSB-first within each frame. It replaces the fixed 8-bit, FIFO-read-strobe transmitter. It sits between the decimation filter/FIFO output and the board TX pin, and honours the host flow-control line at byte boundaries.

Parameters:
CLKS_PER_BIT, 108, clk cycles per UART bit; each bit lasts exactly this many cycles; legal range >= 2.
DATA_BITS, 8, data bits per frame (5..8); low DATA_BITS of each 8-bit lane are sent, upper lane bits are ignored.
STOP_BITS, 1, stop bits per frame (1 or 2).
WORD_BYTES, 4, number of 8-bit lanes per word (1..4).
MSB_BYTE_FIRST, 0, 0 = lane 0 (word_in[7:0]) sent first; 1 = highest lane sent first.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
word_in  in  8*WORD_BYTES  sample word
word_valid  in  1  word_in valid
word_ready  out  1  block can accept a word this cycle
cts_stop  in  1  host flow control; 1 = hold transmission, 0 = send allowed
tx  out  1  serial line, idle high
busy  out  1  high from acceptance until the final stop bit completes
frame_done  out  1  one-cycle pulse at the end of each byte's last stop bit

Behaviour:
- Reset (async): tx=1, word_ready=0, busy=0, frame_done=0; FSM=IDLE; all counters=0. word_ready rises the first cycle after reset release if cts_stop=0.
- word_ready = (state==IDLE) & ~cts_stop (combinational from registered state and cts_stop).
- Accept when word_valid & word_ready: latch word_in into a shift/hold register, set busy, byte index=0, go to START. word_in ignored at all other times.
- States: IDLE, START, DATA, STOP, HOLD (PARITY added with the optional feature).
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx = current lane bit[bit_idx], bit_idx 0..DATA_BITS-1, each CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; in the last cycle pulse frame_done. Then: if more bytes remain and cts_stop=0 -> START of next byte; if more bytes remain and cts_stop=1 -> HOLD; if last byte -> IDLE with busy cleared.
- HOLD: tx=1; stay while cts_stop=1; when cts_stop=0 -> START of next byte. Stop and HOLD do not overlap: HOLD begins after the full stop time.
- cts_stop is never sampled mid-frame; a frame once started always completes.
- tx is registered; the first tx=0 appears on the cycle after the acceptance cycle. Word latency = WORD_BYTES*(1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles with no flow stalls.
- Back-to-back words: the earliest next acceptance is the cycle after busy falls (one idle cycle minimum, tx=1).
- Baud counter width = $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 then wraps. There is no off-by-one extra cycle.
- Reset mid-frame: tx returns to 1 immediately (async); the partial word is discarded.
- word_valid held high while not ready: the word stays pending, with no loss and no duplication.

Optional Feature:
UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives tx = even parity (XOR) of the DATA_BITS sent, for CLKS_PER_BIT cycles. Word latency per byte grows by CLKS_PER_BIT.
UART_TX_PARITY_EN undefined: no parity state and no parity logic; frames are 8N1-style as set by the parameters.

Decomposition:
- Package uart_pkg: state enumeration (IDLE, START, DATA, PARITY, STOP, HOLD), line-level constants (LINE_IDLE=1, START_BIT=0, STOP_BIT=1), and a function for baud-counter width.
- Sub-module uart_baud_tick: a CLKS_PER_BIT divider with a synchronous clear. It emits a bit_end pulse on count CLKS_PER_BIT-1 and is cleared by the FSM on each state entry.

Test Plan:
- CLKS_PER_BIT=4, WORD_BYTES=1, send 0xA5, cts_stop=0 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles. frame_done pulses once at cycle 40 after acceptance; busy clears the same cycle.
- WORD_BYTES=4, word 0x11223344, MSB_BYTE_FIRST=0 -> bytes on the line in order 0x44,0x33,0x22,0x11. Four frame_done pulses 40 cycles apart.
- Same word with cts_stop raised during byte 1 -> byte 1 completes fully; tx stays 1 in HOLD for 20 cycles after its stop bit; byte 2 start bit begins the cycle after cts_stop falls.
- word_valid held high with cts_stop=1 at idle -> word_ready=0 and no transmission. After cts_stop goes to 0, acceptance happens the next cycle and the word is sent exactly once.
- rst asserted mid-DATA of byte 2 -> tx=1, busy=0 and word_ready=0 asynchronously. After release with a new word 0x000000FF, only that new word is transmitted.
- UART_TX_PARITY_EN defined, DATA_BITS=7, byte 0x07 -> the parity bit after data is 1, and the frame is 10 bits (40 cycles at CLKS_PER_BIT=4).
